// File: rtl/multi_vc_fifo.sv
// multi_vc_fifo: NUM_VC virtual-channel FIFOs in one partitioned array, one write and one read port.
// Optional sticky overflow/underflow flags are built when MULTI_VC_FIFO_ERRCHK_EN is defined.
module multi_vc_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int NUM_VC = 4,
  parameter int AFULL_LVL = (1 << ADDR_W) - 1,
  localparam int VC_W = $clog2(NUM_VC),
  localparam int CNT_W = ADDR_W + 1
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic                    i_writeEn,
  input  logic [VC_W-1:0]         i_writeVc,
  input  logic [DATA_W-1:0]       i_writeData,
  input  logic                    i_readEn,
  input  logic [VC_W-1:0]         i_readVc,
  output logic [DATA_W-1:0]       o_readData,
  output logic [NUM_VC-1:0]       o_full,
  output logic [NUM_VC-1:0]       o_empty,
  output logic [NUM_VC-1:0]       o_almostFull,
  output logic [NUM_VC*CNT_W-1:0] o_count,
  output logic [1:0]              o_err,
  input  logic                    i_errClr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] AF = AFULL_LVL[CNT_W-1:0];
  localparam logic [CNT_W-1:0] FULL_XOR = {1'b1, {ADDR_W{1'b0}}};
  logic [CNT_W-1:0] wp [NUM_VC];
  logic [CNT_W-1:0] rp [NUM_VC];
  logic [DATA_W-1:0] mem [NUM_VC*DEPTH];
  logic wr_in, rd_in, wr_ok, rd_ok, rd_valid;
  logic [CNT_W-1:0] wp_sel, rp_sel;
  if (NUM_VC == (1 << VC_W)) begin : g_pow2
    assign wr_in = 1'b1;
    assign rd_in = 1'b1;
  end else begin : g_npow2
    assign wr_in = i_writeVc < VC_W'(NUM_VC);
    assign rd_in = i_readVc < VC_W'(NUM_VC);
  end
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [CNT_W-1:0] cnt;
    assign cnt = wp[v] - rp[v];
    assign o_empty[v] = wp[v] == rp[v];
    assign o_full[v] = (wp[v] ^ rp[v]) == FULL_XOR;
    assign o_almostFull[v] = cnt >= AF;
    assign o_count[v*CNT_W +: CNT_W] = cnt;
  end
  assign wp_sel = wp[i_writeVc];
  assign rp_sel = rp[i_readVc];
  assign wr_ok = i_writeEn && wr_in && !o_full[i_writeVc];
  assign rd_valid = rd_in && !o_empty[i_readVc];
  assign rd_ok = i_readEn && rd_valid;
  assign o_readData = rd_valid ? mem[{i_readVc, rp_sel[ADDR_W-1:0]}] : '0;
  // per-VC pointers advance only on accepted requests; reset is immediate
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      for (int i = 0; i < NUM_VC; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      if (wr_ok) wp[i_writeVc] <= wp_sel + 1'b1;
      if (rd_ok) rp[i_readVc] <= rp_sel + 1'b1;
    end
  // storage is not reset; each VC owns its own DEPTH-word slice
  always_ff @(posedge i_clk)
    if (wr_ok) mem[{i_writeVc, wp_sel[ADDR_W-1:0]}] <= i_writeData;
`ifdef MULTI_VC_FIFO_ERRCHK_EN
  logic [1:0] err;
  // sticky error bits, a new error wins over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) err <= '0;
    else err <= {(err[1] & ~i_errClr) | (i_readEn & ~rd_ok), (err[0] & ~i_errClr) | (i_writeEn & ~wr_ok)};
  assign o_err = err;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_errClr;
  assign o_err = 2'b00;
`endif
endmodule

// File: tb/tb_multi_vc_fifo.sv
// tb_multi_vc_fifo: directed and scoreboard-checked vectors for multi_vc_fifo with default parameters.
module tb_multi_vc_fifo;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic we = 1'b0, re = 1'b0, errc = 1'b0;
  logic [1:0] wvc = '0, rvc = '0;
  logic [7:0] wd = '0;
  logic [7:0] rdata;
  logic [3:0] full, empty, afull;
  logic [11:0] count;
  logic [1:0] err;
  int n_vec = 0;
  int n_miss = 0;
  logic [7:0] m_data [4][4];
  int m_h [4];
  int m_c [4];
  logic [3:0] e_empty, e_full, e_afull;
  logic [11:0] e_count;
  logic [7:0] e_rdata;
  logic wa, ra;
`ifdef MULTI_VC_FIFO_ERRCHK_EN
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
`else
  localparam logic [1:0] ERR_OVF = 2'b00;
  localparam logic [1:0] ERR_UNF = 2'b00;
`endif

  multi_vc_fifo dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_writeEn(we), .i_writeVc(wvc), .i_writeData(wd),
    .i_readEn(re), .i_readVc(rvc), .o_readData(rdata),
    .o_full(full), .o_empty(empty), .o_almostFull(afull), .o_count(count),
    .o_err(err), .i_errClr(errc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] wv, input logic [7:0] d, input logic r, input logic [1:0] rv);
    we = w; wvc = wv; wd = d; re = r; rvc = rv;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; errc = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_afull", 32'(afull), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd2, 8'(8'hA0 + i), 1'b0, 2'd0);
      if (i == 1) chk("afull_2wr", 32'(afull), 32'h0);
      if (i == 2) chk("afull_3wr", 32'(afull), 32'h4);
    end
    chk("vc2_full", 32'(full), 32'h4);
    chk("vc2_count", 32'(count), 32'h100);
    chk("vc2_empty", 32'(empty), 32'hB);
    for (int i = 0; i < 4; i++) begin
      rvc = 2'd2;
      #1;
      chk("vc2_head", 32'(rdata), 32'(8'hA0 + i));
      drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    end
    chk("vc2_drained", 32'(empty), 32'hF);
    chk("vc2_rdata0", 32'(rdata), 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd0, 8'(8'h10 + i), 1'b0, 2'd0);
    chk("vc0_full", 32'(full), 32'h1);
    chk("vc0_head", 32'(rdata), 32'h10);
    drive(1'b1, 2'd0, 8'h55, 1'b1, 2'd0);
    chk("fullsim_count", 32'(count), 32'h003);
    chk("fullsim_head", 32'(rdata), 32'h11);
    chk("fullsim_full", 32'(full), 32'h0);
    chk("fullsim_err", 32'(err), 32'(ERR_OVF));
    errc = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    chk("errclr1", 32'(err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("vc0_drain", 32'(rdata), 32'(8'h11 + i));
      drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    end
    chk("vc0_empty", 32'(empty), 32'hF);
    drive(1'b1, 2'd3, 8'h7E, 1'b1, 2'd3);
    chk("emptysim_count", 32'(count), 32'h200);
    chk("emptysim_rdata", 32'(rdata), 32'h7E);
    chk("emptysim_err", 32'(err), 32'(ERR_UNF));
    errc = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd3);
    chk("errclr2", 32'(err), 32'h0);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    chk("vc3_empty", 32'(empty), 32'hF);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'd1, 8'(i), 1'b0, 2'd1);
      chk("wrap_data", 32'(rdata), 32'(i));
      chk("wrap_count", 32'(count), 32'h008);
      chk("wrap_full", 32'(full), 32'h0);
      drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    end
    chk("wrap_empty", 32'(empty), 32'hF);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, 8'(8'hC0 + i), 1'b0, 2'd1);
    chk("pre_rst_count", 32'(count), 32'h018);
    chk("pre_rst_rdata", 32'(rdata), 32'hC0);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'hF);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_rdata", 32'(rdata), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int v = 0; v < 4; v++) begin
      m_h[v] = 0;
      m_c[v] = 0;
    end
    for (int i = 0; i < 1000; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wvc = 2'($urandom_range(0, 3));
      rvc = 2'($urandom_range(0, 3));
      wd = 8'($urandom_range(0, 255));
      #1;
      for (int v = 0; v < 4; v++) begin
        e_empty[v] = m_c[v] == 0;
        e_full[v] = m_c[v] == 4;
        e_afull[v] = m_c[v] >= 3;
        e_count[v*3 +: 3] = 3'(m_c[v]);
      end
      e_rdata = m_c[rvc] > 0 ? m_data[rvc][m_h[rvc]] : 8'h00;
      chk("rnd_rdata", 32'(rdata), 32'(e_rdata));
      chk("rnd_empty", 32'(empty), 32'(e_empty));
      chk("rnd_full", 32'(full), 32'(e_full));
      chk("rnd_afull", 32'(afull), 32'(e_afull));
      chk("rnd_count", 32'(count), 32'(e_count));
      wa = we && m_c[wvc] < 4;
      ra = re && m_c[rvc] > 0;
      @(posedge clk);
      #1;
      if (ra) begin
        m_h[rvc] = (m_h[rvc] + 1) % 4;
        m_c[rvc]--;
      end
      if (wa) begin
        m_data[wvc][(m_h[wvc] + m_c[wvc]) % 4] = wd;
        m_c[wvc]++;
      end
    end
    we = 1'b0;
    re = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/multi_vc_fifo.md
# multi_vc_fifo

Multi-channel synchronous FIFO for the NoC router input ports. It holds NUM_VC independent virtual-channel (VC) queues in one shared, statically partitioned storage array, with one write port and one read port. Each port selects a VC per cycle. Per-VC full, empty, almost-full and occupancy outputs feed the credit logic and the output-port arbiter.

## Interface
Parameters:
- DATA_W, 8, flit width in bits.
- ADDR_W, 2, log2 of per-VC depth; DEPTH = 1 << ADDR_W; must be ≥1.
- NUM_VC, 4, number of virtual channels; ≥2.
- AFULL_LVL, DEPTH-1, occupancy at or above which o_almostFull[v] asserts; legal range 1..DEPTH.
- Derived: VC_W = $clog2(NUM_VC); CNT_W = ADDR_W+1.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_arst_n  input  1  reset, asynchronous, active-low.
- i_writeEn  input  1  write request.
- i_writeVc  input  VC_W  target VC of the write.
- i_writeData  input  DATA_W  flit to enqueue.
- i_readEn  input  1  read (pop) request.
- i_readVc  input  VC_W  VC to read/pop.
- o_readData  output  DATA_W  head flit of i_readVc, combinational.
- o_full  output  NUM_VC  per-VC full.
- o_empty  output  NUM_VC  per-VC empty.
- o_almostFull  output  NUM_VC  per-VC count ≥ AFULL_LVL.
- o_count  output  NUM_VC*CNT_W  per-VC occupancy; VC v at bits [v*CNT_W +: CNT_W].
- o_err  output  2  sticky {underflow, overflow}; see Configuration.
- i_errClr  input  1  clears o_err.

## Operation
- Each VC has its own write and read pointer, both CNT_W wide. The extra MSB distinguishes full from empty.
  - empty[v]: pointers equal.
  - full[v]: MSBs differ and the low ADDR_W bits are equal.
  - count[v] = wp[v] − rp[v], modulo 2^CNT_W.
- Storage: NUM_VC*DEPTH words. VC v occupies addresses [v*DEPTH, v*DEPTH+DEPTH−1]. Storage has no reset.
- A write is accepted when i_writeEn && i_writeVc < NUM_VC && !o_full[i_writeVc]. An accepted write stores the data and increments wp[i_writeVc].
- A read is accepted when i_readEn && i_readVc < NUM_VC && !o_empty[i_readVc]. An accepted read increments rp[i_readVc].
- o_readData:
  - Equals mem[i_readVc*DEPTH + rp[i_readVc][ADDR_W-1:0]] (first-word fall-through).
  - Is forced to 0 when the selected VC is empty or i_readVc ≥ NUM_VC.
- Rejected requests change no state.
- Pointers wrap naturally modulo 2^CNT_W.

Boundary conditions:
- Simultaneous write and read to the same VC: both are judged on pre-edge flags.
  - VC full: the read is accepted and the write is rejected, so count drops by 1.
  - VC empty: the write is accepted and the read is rejected, so count rises by 1.
  - Otherwise: both are accepted and count is unchanged.
- Write and read to different VCs are fully independent.
- Out-of-range VC index (only possible when NUM_VC is not a power of 2): the request is dropped.
- Reset asserted mid-operation clears all pointers immediately, with no clock required. Stored data becomes unreachable.

## Timing
- Reset values:
  - o_empty all 1.
  - o_full, o_almostFull, o_count, o_err all 0.
  - o_readData 0.
- Flags and counts are pure functions of registered pointers. They update on the clock edge that accepts a request.
- Write-to-read latency: 1 cycle. A flit written at edge N is on o_readData from just after edge N, provided it is the head and its VC is selected.
- A pop at edge N presents the next head immediately after edge N.
- Throughput: one write and one read per cycle, sustained.
- No combinational path from i_writeEn/i_readEn to any flag.

## Configuration
- MULTI_VC_FIFO_ERRCHK_EN defined:
  - o_err[0] (overflow) sets on the edge where i_writeEn is high and the write is rejected.
  - o_err[1] (underflow) sets on the edge where i_readEn is high and the read is rejected.
  - Bits stay set until i_errClr is sampled high. Set has priority over clear in the same cycle.
- MULTI_VC_FIFO_ERRCHK_EN not defined: o_err is tied to 2'b00, i_errClr is ignored, and no error registers exist.
- Request acceptance behaviour is identical in both builds.

## Test plan
- Reset: assert i_arst_n=0 mid-stream with VC1 holding 3 flits -> o_empty=4'b1111, o_count all 0, o_readData=0, before the next clock edge.
- Per-VC isolation (defaults): write 0xA0..0xA3 to VC2 -> o_full=4'b0100, o_count[VC2]=4, o_almostFull[2]=1 after the third write. The other VCs stay empty. Read VC2 four times -> 0xA0,0xA1,0xA2,0xA3 in order.
- Full + simultaneous: with VC0 full, write 0x55 and read VC0 on the same edge -> read returns the old head, write is dropped, count[VC0]=3, o_err=2'b01 (ERRCHK build).
- Empty + simultaneous: with VC3 empty, write 0x7E and read VC3 on the same edge -> count[VC3]=1, o_readData=0x7E the next cycle, o_err=2'b10 (ERRCHK build). i_errClr for one cycle -> o_err=0.
- Wrap-around: 20 write/read pairs on VC1 with data equal to the index -> data returned in order 0..19, o_full never asserts, count[VC1] stays ≤1.
- Interleaved traffic: random VCs, writes and reads every cycle for 1000 cycles against a scoreboard -> zero data mismatches, and flags consistent with the model every cycle.
